vc_reset_seq: RTL and testbench

//  Parametrised reset/enable sequencer for the vc CPU core, between the tt_um top pads and vc.reset.
//  - Synchronises external rst_n and ena, then stretches reset for a programmable number of cycles.
//  - Latches boot-mode straps at release and drives the registered core reset.
//  - Adds a kickable watchdog that re-resets the core and records the cause of the last reset.

---
 rtl/vc_reset_seq_if.sv | 26 ++
 rtl/vc_reset_seq.sv | 141 ++++++++++++++
 tb/tb_vc_reset_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vc_reset_seq_if.sv
// vc_reset_seq_if: pad/core-side signal bundle for the vc reset sequencer.
// slave = the sequencer itself, master = whatever drives the pads and core CSRs.
interface vc_reset_seq_if #(
  parameter int BOOT_W = 2
);
  logic              rst_n_in;
  logic              ena;
  logic [BOOT_W-1:0] boot_in;
  logic              wdog_en;
  logic              wdog_kick;
  logic              cpu_reset;
  logic [BOOT_W-1:0] boot_mode;
  logic              boot_valid;
  logic              wdog_fired;
  logic [1:0]        reset_cause;

  modport master (
    output rst_n_in, ena, boot_in, wdog_en, wdog_kick,
    input  cpu_reset, boot_mode, boot_valid, wdog_fired, reset_cause
  );

  modport slave (
    input  rst_n_in, ena, boot_in, wdog_en, wdog_kick,
    output cpu_reset, boot_mode, boot_valid, wdog_fired, reset_cause
  );
endinterface

// File: rtl/vc_reset_seq.sv
// vc_reset_seq: synchronises pad reset/enable, stretches the core reset,
// latches boot straps on release and runs a kickable watchdog that
// re-resets the core. reset_cause records why the core was last reset.
module vc_reset_seq #(
  parameter int          SYNC_STAGES = 2,
  parameter int          STRETCH     = 16,
  parameter int          BOOT_W      = 2,
  parameter int unsigned WDOG_LIMIT  = 24'd10_000_000
) (
  input  logic           clk,
  input  logic           reset,
  vc_reset_seq_if.slave  bus
);

  localparam int CNT_W  = $clog2(STRETCH + 1);
  localparam int WCNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [WCNT_W-1:0] WCNT_TOP = WCNT_W'(WDOG_LIMIT - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_PAD  = 2'b01;
  localparam logic [1:0] CAUSE_ENA  = 2'b10;
  localparam logic [1:0] CAUSE_WDOG = 2'b11;

  typedef enum logic [2:0] {
    S_HOLD, S_STRETCH, S_SAMPLE, S_RUN, S_TRIP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] rst_sync, ena_sync;
  logic                   rst_s, ena_s, src_ok;

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;

  logic              abort_entry, sample_en, wdog_hit;

  logic              cpu_reset_q;
  logic [BOOT_W-1:0] boot_mode_q;
  logic              boot_valid_q;
  logic              wdog_fired_q;
  logic [1:0]        reset_cause_q;

  // Two-or-more flop synchronisers; power-on reset makes both sources look asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync <= '0;
      ena_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], bus.rst_n_in};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], bus.ena};
    end
  end

  assign rst_s  = rst_sync[SYNC_STAGES-1];
  assign ena_s  = ena_sync[SYNC_STAGES-1];
  assign src_ok = rst_s & ena_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HOLD;
    else       state <= state_nxt;
  end

  // Next state: a dropped source forces HOLD from anywhere, else normal sequencing.
  always_comb begin
    state_nxt = state;
    wdog_hit  = bus.wdog_en && !bus.wdog_kick && (wcnt == WCNT_TOP);
    if (!src_ok) begin
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_HOLD:    state_nxt = S_STRETCH;
        S_STRETCH: if (cnt == '0) state_nxt = S_SAMPLE;
        S_SAMPLE:  state_nxt = S_RUN;
        S_RUN:     if (wdog_hit) state_nxt = S_TRIP;
        S_TRIP:    state_nxt = S_STRETCH;
        default:   state_nxt = S_HOLD;
      endcase
    end
  end

  // Output/datapath decode: counter next values and one-shot strobes.
  always_comb begin
    abort_entry = (state != S_HOLD) && (state_nxt == S_HOLD);
    sample_en   = (state == S_SAMPLE) && (state_nxt == S_RUN);

    // Stretch counter reloads on every entry into STRETCH, so an abort restarts the full stretch.
    cnt_nxt = cnt;
    if (state_nxt == S_STRETCH && state != S_STRETCH)
      cnt_nxt = CNT_LOAD;
    else if (state == S_STRETCH && cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);

    // Watchdog only counts while staying in RUN; a kick on the limit cycle keeps us in RUN.
    wcnt_nxt = '0;
    if (state == S_RUN && state_nxt == S_RUN) begin
      if (!bus.wdog_en || bus.wdog_kick) wcnt_nxt = '0;
      else                               wcnt_nxt = wcnt + WCNT_W'(1);
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      wcnt          <= '0;
      cpu_reset_q   <= 1'b1;
      boot_mode_q   <= '0;
      boot_valid_q  <= 1'b0;
      wdog_fired_q  <= 1'b0;
      reset_cause_q <= CAUSE_POR;
    end else begin
      cnt         <= cnt_nxt;
      wcnt        <= wcnt_nxt;
      // Registered off next_state so it drops exactly on RUN entry, glitch-free.
      cpu_reset_q <= (state_nxt != S_RUN);

      if (sample_en) boot_mode_q <= bus.boot_in;

      if (abort_entry)    boot_valid_q <= 1'b0;
      else if (sample_en) boot_valid_q <= 1'b1;

      // Cause is only written on the edge that enters HOLD, never refreshed inside it.
      if (abort_entry)          reset_cause_q <= rst_s ? CAUSE_ENA : CAUSE_PAD;
      else if (state == S_TRIP) reset_cause_q <= CAUSE_WDOG;

      // Sticky trip flag; the pad reset clears it, ena does not.
      if (!rst_s)               wdog_fired_q <= 1'b0;
      else if (state == S_TRIP) wdog_fired_q <= 1'b1;
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.boot_mode   = boot_mode_q;
  assign bus.boot_valid  = boot_valid_q;
  assign bus.wdog_fired  = wdog_fired_q;
  assign bus.reset_cause = reset_cause_q;

endmodule

// File: tb/tb_vc_reset_seq.sv
// tb_vc_reset_seq: directed vectors for vc_reset_seq with a short watchdog.
module tb_vc_reset_seq;

  localparam int BOOT_W = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   n;
  logic run_ok;

  vc_reset_seq_if #(.BOOT_W(BOOT_W)) bus ();

  vc_reset_seq #(
    .SYNC_STAGES(2),
    .STRETCH    (16),
    .BOOT_W     (BOOT_W),
    .WDOG_LIMIT (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges (first edge = 1) until cpu_reset reaches lvl; bounded.
  task automatic wait_level(input logic lvl, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.cpu_reset !== lvl && cnt < 100);
  endtask

  initial begin
    reset         = 1'b1;
    bus.rst_n_in  = 1'b1;
    bus.ena       = 1'b1;
    bus.boot_in   = 2'b10;
    bus.wdog_en   = 1'b0;
    bus.wdog_kick = 1'b0;
    repeat (3) tick();

    // 1. power-on reset state and first release
    chk("por_cpu_reset",   32'(bus.cpu_reset),   32'd1);
    chk("por_boot_mode",   32'(bus.boot_mode),   32'd0);
    chk("por_boot_valid",  32'(bus.boot_valid),  32'd0);
    chk("por_wdog_fired",  32'(bus.wdog_fired),  32'd0);
    chk("por_cause",       32'(bus.reset_cause), 32'd0);
    reset = 1'b0;
    // E0 is the first edge; the fall lands on E0+19, the 20th edge counted
    wait_level(1'b0, n);
    chk("t1_release_edges", 32'(n),               32'd20);
    chk("t1_boot_mode",     32'(bus.boot_mode),   32'd2);
    chk("t1_boot_valid",    32'(bus.boot_valid),  32'd1);
    chk("t1_cause",         32'(bus.reset_cause), 32'd0);

    // 2. one-cycle pad reset while running
    bus.rst_n_in = 1'b0;
    tick();                                   // Ea samples the low
    chk("t2_ea_still_run", 32'(bus.cpu_reset), 32'd0);
    bus.rst_n_in = 1'b1;
    tick();                                   // Ea+1
    chk("t2_ea1_still_run", 32'(bus.cpu_reset), 32'd0);
    tick();                                   // Ea+2: third edge
    chk("t2_asserted",   32'(bus.cpu_reset),   32'd1);
    chk("t2_cause",      32'(bus.reset_cause), 32'd1);
    chk("t2_boot_valid", 32'(bus.boot_valid),  32'd0);
    // re-release sampled at Ea+1, fall at Ea+20: 18 edges beyond Ea+2
    wait_level(1'b0, n);
    chk("t2_rerelease_edges", 32'(n), 32'd18);

    // 5. ena low mid-STRETCH, then pad reset inside HOLD
    bus.rst_n_in = 1'b0;
    tick();
    bus.rst_n_in = 1'b1;
    repeat (8) tick();                        // well inside STRETCH
    chk("t5_in_stretch", 32'(bus.cpu_reset), 32'd1);
    bus.ena = 1'b0;
    repeat (3) tick();                        // HOLD entry two edges after sampling
    chk("t5_cause_ena", 32'(bus.reset_cause), 32'd2);
    bus.rst_n_in = 1'b0;
    repeat (4) tick();
    chk("t5_cause_held", 32'(bus.reset_cause), 32'd2);
    bus.rst_n_in = 1'b1;
    repeat (4) tick();
    chk("t5_hold_no_ena", 32'(bus.cpu_reset), 32'd1);
    bus.ena = 1'b1;
    wait_level(1'b0, n);
    chk("t5_full_latency",  32'(n),               32'd20);
    chk("t5_cause_after",   32'(bus.reset_cause), 32'd2);
    chk("t5_boot_valid",    32'(bus.boot_valid),  32'd1);

    // 3. watchdog trip with no kicks, straps change during the re-reset
    bus.wdog_en = 1'b1;
    wait_level(1'b1, n);
    chk("t3_trip_edges", 32'(n), 32'd8);
    tick();                                   // TRIP committed
    chk("t3_fired", 32'(bus.wdog_fired),  32'd1);
    chk("t3_cause", 32'(bus.reset_cause), 32'd3);
    bus.boot_in = 2'b01;
    // cpu_reset high for 18 edges total; one already consumed
    wait_level(1'b0, n);
    chk("t3_reset_width", 32'(n),              32'd17);
    chk("t3_boot_mode",   32'(bus.boot_mode),  32'd1);
    chk("t3_boot_valid",  32'(bus.boot_valid), 32'd1);
    chk("t3_fired_kept",  32'(bus.wdog_fired), 32'd1);

    // 4. kick exactly on the limit cycle, then periodic kicks
    repeat (7) tick();                        // wcnt at limit-1
    bus.wdog_kick = 1'b1;
    tick();
    bus.wdog_kick = 1'b0;
    chk("t4_limit_kick", 32'(bus.cpu_reset), 32'd0);
    run_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.wdog_kick = (i % 7 == 6);
      tick();
      if (bus.cpu_reset !== 1'b0) run_ok = 1'b0;
    end
    bus.wdog_kick = 1'b0;
    chk("t4_no_trip_1000", 32'(run_ok), 32'd1);

    // 6. wdog_en pulsed low at wcnt=5 restarts the count
    bus.wdog_kick = 1'b1;
    tick();
    bus.wdog_kick = 1'b0;
    repeat (5) tick();
    chk("t6_still_run", 32'(bus.cpu_reset), 32'd0);
    bus.wdog_en = 1'b0;
    tick();
    bus.wdog_en = 1'b1;
    wait_level(1'b1, n);
    chk("t6_trip_edges", 32'(n), 32'd8);

    // ena low keeps the sticky flag; pad reset clears it and cause stays ena
    bus.ena = 1'b0;
    repeat (4) tick();
    chk("t7_cause_ena",    32'(bus.reset_cause), 32'd2);
    chk("t7_fired_kept",   32'(bus.wdog_fired),  32'd1);
    chk("t7_cpu_reset",    32'(bus.cpu_reset),   32'd1);
    bus.rst_n_in = 1'b0;
    repeat (4) tick();
    chk("t7_fired_clear",  32'(bus.wdog_fired),  32'd0);
    chk("t7_cause_stays",  32'(bus.reset_cause), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
